coproc_sample_sequencer: RTL and testbench

COPROC_SAMPLE_SEQUENCER -- requirements
Module: coproc_sample_sequencer

---
 rtl/coproc_sample_sequencer.sv | 145 ++++++++++++++
 tb/tb_coproc_sample_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/coproc_sample_sequencer.sv
// coproc_sample_sequencer: feeds T/dT samples to a coprocessor, waits for its result with a timeout, and queues results.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   sample_valid/ready, sample_T,
//   sample_dT, sample_first        - sample input handshake (first requests a coprocessor INIT)
//   cp_start, cp_init, cp_T_in,
//   cp_dT_in                       - coprocessor command pulses and held operands
//   cp_valid, cp_G_out             - coprocessor done pulse and result
//   res_valid/ready, res_G,
//   res_timeout, res_range_err     - result output handshake
//   busy                           - sequencer not idle
//   stray_cnt                      - saturating count of cp_valid pulses outside WAIT
// Build option: define SEQ_RESULT_FIFO_EN for a 4-entry first-word-fall-through result FIFO;
// otherwise a single result register is used.
module coproc_sample_sequencer #(
    parameter int TIMEOUT_CYC = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic signed [7:0] sample_T,
    input  logic signed [7:0] sample_dT,
    input  logic              sample_first,
    output logic              cp_start,
    output logic              cp_init,
    output logic signed [7:0] cp_T_in,
    output logic signed [7:0] cp_dT_in,
    input  logic              cp_valid,
    input  logic        [7:0] cp_G_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic        [7:0] res_G,
    output logic              res_timeout,
    output logic              res_range_err,
    output logic              busy,
    output logic        [7:0] stray_cnt
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, INIT, START, WAIT, CAPTURE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          accept, timeout_hit, full, push, pop;
    logic    [7:0] push_g;
    logic          push_to, push_re;

    assign accept       = sample_valid && sample_ready;
    assign sample_ready = (state == IDLE) && !full;
    // The timeout fires on the TIMEOUT_CYC-th WAIT cycle, unless cp_valid arrives in that same cycle.
    assign timeout_hit  = (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = sample_first ? INIT : START;
            INIT:    state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    state_nx = cp_valid ? CAPTURE : (timeout_hit ? IDLE : WAIT);
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cp_init = (state == INIT);
        cp_start = (state == START);
        busy = (state != IDLE);
        push = (state == CAPTURE) || (state == WAIT && !cp_valid && timeout_hit);
        push_to = (state == WAIT);
        push_re = (state == CAPTURE) && (cp_G_out > 8'd100);
        push_g = (state != CAPTURE) ? 8'd0 : (push_re ? 8'd100 : cp_G_out);
    end

    // Operands are only reloaded on acceptance, so they stay put for the whole transaction.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cp_T_in  <= '0;
            cp_dT_in <= '0;
        end else if (accept) begin
            cp_T_in  <= sample_T;
            cp_dT_in <= sample_dT;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)               cnt <= '0;
        else if (state == START)  cnt <= '0;
        else if (state == WAIT)   cnt <= cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                                           stray_cnt <= '0;
        else if (cp_valid && state != WAIT && stray_cnt != 8'hFF) stray_cnt <= stray_cnt + 8'd1;

    assign pop = res_valid && res_ready;

`ifdef SEQ_RESULT_FIFO_EN
    logic [9:0] mem [4];
    logic [1:0] rd, wr;
    logic [2:0] count;

    assign full      = (count == 3'd4);
    assign res_valid = (count != 3'd0);
    assign {res_G, res_timeout, res_range_err} = mem[rd];

    // Entries are cleared on reset so the fall-through head reads as zero when empty.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr] <= {push_g, push_to, push_re};
                wr      <= wr + 2'd1;
            end
            if (pop) rd <= rd + 2'd1;
            count <= count + 3'(push) - 3'(pop);
        end
`else
    assign full = res_valid && !res_ready;

    // A push only happens into an empty or simultaneously-popped register, since acceptance required !full.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            res_valid     <= 1'b0;
            res_G         <= '0;
            res_timeout   <= 1'b0;
            res_range_err <= 1'b0;
        end else if (push) begin
            res_valid     <= 1'b1;
            res_G         <= push_g;
            res_timeout   <= push_to;
            res_range_err <= push_re;
        end else if (pop) begin
            res_valid     <= 1'b0;
        end
`endif

endmodule

// File: tb/tb_coproc_sample_sequencer.sv
// tb_coproc_sample_sequencer: directed self-checking bench for coproc_sample_sequencer.
module tb_coproc_sample_sequencer;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              sample_valid, sample_first, cp_valid, res_ready;
    logic signed [7:0] sample_T, sample_dT;
    logic        [7:0] cp_G_out;
    logic              sample_ready, cp_start, cp_init, res_valid, res_timeout, res_range_err, busy;
    logic signed [7:0] cp_T_in, cp_dT_in;
    logic        [7:0] res_G, stray_cnt;

    int passed = 0;
    int total = 0;
    int n_start = 0;
    int n_init = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cp_start) n_start <= n_start + 1;
        if (cp_init) n_init <= n_init + 1;
    end

    coproc_sample_sequencer #(.TIMEOUT_CYC(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_T(sample_T), .sample_dT(sample_dT), .sample_first(sample_first),
        .cp_start(cp_start), .cp_init(cp_init), .cp_T_in(cp_T_in), .cp_dT_in(cp_dT_in),
        .cp_valid(cp_valid), .cp_G_out(cp_G_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_G(res_G),
        .res_timeout(res_timeout), .res_range_err(res_range_err),
        .busy(busy), .stray_cnt(stray_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Offer one sample at the current negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic signed [7:0] t, input logic signed [7:0] dt, input logic first);
        sample_valid = 1'b1;
        sample_T = t;
        sample_dT = dt;
        sample_first = first;
        @(negedge clk);
        sample_valid = 1'b0;
        sample_first = 1'b0;
    endtask

    // Called in the START cycle: pulse cp_valid lat cycles after start, return in the idle cycle after the push.
    task automatic serve(input int lat, input logic [7:0] g);
        repeat (lat) @(negedge clk);
        cp_valid = 1'b1;
        cp_G_out = g;
        @(negedge clk);
        cp_valid = 1'b0;
        @(negedge clk);
        cp_G_out = 8'd0;
    endtask

    initial begin
        int s0;
        int acc;
        int exp_acc;
        rst_n = 1'b0;
        sample_valid = 1'b0;
        sample_first = 1'b0;
        sample_T = '0;
        sample_dT = '0;
        cp_valid = 1'b0;
        cp_G_out = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_res_valid", {7'd0, res_valid}, 8'd0);
        chk("rst_cp_start", {7'd0, cp_start}, 8'd0);
        rst_n = 1'b1;
        chk("ready_after_rst", {7'd0, sample_ready}, 8'd1);
        chk("rst_stray", stray_cnt, 8'd0);

        // Plain sample, result 50 after 5 cycles.
        s0 = n_start;
        send(8'sd16, 8'sd0, 1'b0);
        chk("s1_start_lat1", {7'd0, cp_start}, 8'd1);
        chk("s1_T_in", cp_T_in, 8'd16);
        chk("s1_ready_busy", {7'd0, sample_ready}, 8'd0);
        serve(5, 8'd50);
        chk("s1_res_valid", {7'd0, res_valid}, 8'd1);
        chk("s1_res_G", res_G, 8'd50);
        chk("s1_timeout", {7'd0, res_timeout}, 8'd0);
        chk("s1_range", {7'd0, res_range_err}, 8'd0);
        chk("s1_one_start", 8'(n_start - s0), 8'd1);
        @(negedge clk);
        chk("s1_hold_valid", {7'd0, res_valid}, 8'd1);
        chk("s1_hold_G", res_G, 8'd50);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("s1_popped", {7'd0, res_valid}, 8'd0);

        // Stray cp_valid while idle.
        cp_valid = 1'b1;
        @(negedge clk);
        cp_valid = 1'b0;
        chk("stray_idle", stray_cnt, 8'd1);
        chk("stray_no_push", {7'd0, res_valid}, 8'd0);

        // First sample: INIT then START, result 120 clamps.
        s0 = n_init;
        send(-8'sd4, 8'sd7, 1'b1);
        chk("s2_init", {7'd0, cp_init}, 8'd1);
        chk("s2_no_start_yet", {7'd0, cp_start}, 8'd0);
        @(negedge clk);
        chk("s2_start", {7'd0, cp_start}, 8'd1);
        chk("s2_init_done", {7'd0, cp_init}, 8'd0);
        serve(1, 8'd120);
        chk("s2_res_G", res_G, 8'd100);
        chk("s2_range", {7'd0, res_range_err}, 8'd1);
        chk("s2_one_init", 8'(n_init - s0), 8'd1);
        res_ready = 1'b1;
        @(negedge clk);
        chk("s2_popped", {7'd0, res_valid}, 8'd0);

        // Timeout after 32 WAIT cycles (res_ready stays high).
        send(8'sd1, 8'sd1, 1'b0);
        repeat (32) @(negedge clk);
        chk("to_busy_32", {7'd0, busy}, 8'd1);
        chk("to_no_res_yet", {7'd0, res_valid}, 8'd0);
        @(negedge clk);
        chk("to_res_valid", {7'd0, res_valid}, 8'd1);
        chk("to_flag", {7'd0, res_timeout}, 8'd1);
        chk("to_G", res_G, 8'd0);
        chk("to_ready", {7'd0, sample_ready}, 8'd1);
        @(negedge clk);
        chk("to_popped", {7'd0, res_valid}, 8'd0);
        res_ready = 1'b0;

        // cp_valid on the last WAIT cycle beats the timeout.
        send(8'sd2, 8'sd2, 1'b0);
        repeat (32) @(negedge clk);
        cp_valid = 1'b1;
        cp_G_out = 8'd77;
        @(negedge clk);
        cp_valid = 1'b0;
        @(negedge clk);
        cp_G_out = 8'd0;
        chk("vw_G", res_G, 8'd77);
        chk("vw_timeout", {7'd0, res_timeout}, 8'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("vw_single", {7'd0, res_valid}, 8'd0);

        // Backpressure: five offers with res_ready low.
`ifdef SEQ_RESULT_FIFO_EN
        exp_acc = 4;
`else
        exp_acc = 1;
`endif
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (sample_ready) begin
                send(8'(i), 8'sd0, 1'b0);
                serve(1, 8'(10 + i));
                acc++;
            end else begin
                sample_valid = 1'b1;
                @(negedge clk);
                sample_valid = 1'b0;
                chk("bp_rejected", {7'd0, busy}, 8'd0);
            end
        end
        chk("bp_accepted", 8'(acc), 8'(exp_acc));
        res_ready = 1'b1;
        for (int j = 0; j < exp_acc; j++) begin
            chk("bp_drain_G", res_G, 8'(10 + j));
            @(negedge clk);
        end
        res_ready = 1'b0;
        chk("bp_empty", {7'd0, res_valid}, 8'd0);

        // Reset mid-WAIT, then a stray cp_valid.
        send(8'sd5, -8'sd3, 1'b0);
        chk("rw_dT_in", cp_dT_in, 8'hFD);
        @(negedge clk);
        chk("rw_busy", {7'd0, busy}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_busy0", {7'd0, busy}, 8'd0);
        chk("rw_T0", cp_T_in, 8'd0);
        chk("rw_dT0", cp_dT_in, 8'd0);
        chk("rw_stray0", stray_cnt, 8'd0);
        chk("rw_start0", {7'd0, cp_start}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rw_ready", {7'd0, sample_ready}, 8'd1);
        cp_valid = 1'b1;
        @(negedge clk);
        cp_valid = 1'b0;
        chk("rw_stray1", stray_cnt, 8'd1);
        @(negedge clk);
        chk("rw_no_push", {7'd0, res_valid}, 8'd0);
        chk("rw_res_G", res_G, 8'd0);
        chk("rw_idle", {7'd0, busy}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
